// File: rtl/cpu10_pkg.sv
// Shared definitions for the 10-bit CPU slice: word/address widths used by the
// core, ROM, RAM and the instruction loader, plus the loader state encoding.
package cpu10_pkg;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 10;

    // The loader checksum is a running sum modulo 2^DATA_W.
    localparam int CSUM_W = DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } ldr_state_e;

endpackage

// File: rtl/instr_loader.sv
// Instruction loader: takes a valid/ready stream of program words, writes them
// to instruction memory from address 0, verifies a trailing checksum word and
// then releases the CPU core from reset after a short settle period.
module instr_loader #(
    parameter int DATA_W        = cpu10_pkg::DATA_W,
    parameter int ADDR_W        = cpu10_pkg::ADDR_W,
    parameter int DEPTH         = 1024,
    parameter int RELEASE_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic [ADDR_W:0]   loaded_words,
    output logic              done,
    output logic              error
);
    import cpu10_pkg::*;

    localparam int CNT_W = ADDR_W + 1;
    localparam int DLY_W = $clog2(RELEASE_DELAY + 1);

    // Checksum accumulate: plain wrap-around sum, carry discarded.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W-1:0];
    endfunction

    ldr_state_e        state_q;
    logic              in_ready_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              cpu_rst_q;
    logic [CNT_W-1:0]  count_q;
    logic              done_q;
    logic              error_q;
    logic [DATA_W-1:0] csum_q;
    logic [DLY_W-1:0]  dly_q;

    logic              xfer_d;
    logic              full_d;
    logic [DATA_W-1:0] csum_d;
    logic [CNT_W-1:0]  count_d;
    logic              dly_done_d;

    // Next-value datapath terms shared by the FSM below.
    always_comb begin
        xfer_d     = in_valid & in_ready_q;
        full_d     = (count_q >= CNT_W'(DEPTH));
        csum_d     = wrap_add(csum_q, in_data);
        count_d    = count_q + 1'b1;
        dly_done_d = (dly_q == DLY_W'(RELEASE_DELAY - 1));
    end

    // Loader FSM with all outputs registered; imem_we defaults low so each
    // accepted word produces exactly one write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rst_q  <= 1'b1;
            count_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            csum_q     <= '0;
            dly_q      <= '0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    // A new load may be launched from any resting state.
                    if (start) begin
                        state_q    <= ST_LOAD;
                        in_ready_q <= 1'b1;
                        cpu_rst_q  <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                        count_q    <= '0;
                        csum_q     <= '0;
                    end
                end
                ST_LOAD: begin
                    if (xfer_d) begin
                        if (in_last) begin
                            in_ready_q <= 1'b0;
                            if (in_data == csum_q) begin
                                state_q <= ST_SETTLE;
                                dly_q   <= '0;
                            end else begin
                                state_q <= ST_ERROR;
                                error_q <= 1'b1;
                            end
                        end else if (full_d) begin
                            // Program longer than memory: refuse the word.
                            state_q    <= ST_ERROR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            addr_q  <= count_q[ADDR_W-1:0];
                            wdata_q <= in_data;
                            count_q <= count_d;
                            csum_q  <= csum_d;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Hold the core in reset until the last write has landed.
                    dly_q <= dly_q + 1'b1;
                    if (dly_done_d) begin
                        state_q   <= ST_RUN;
                        cpu_rst_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    cpu_rst_q  <= 1'b1;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign loaded_words = count_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a full-size instance and a DEPTH=4 instance
// for the overflow case, both driven from one sequential stimulus block.
module tb_instr_loader;

    localparam int DW = 10;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Shared stimulus, steered to one instance by sel_small.
    logic          sel_small = 1'b0;
    logic          drv_start = 1'b0;
    logic          drv_valid = 1'b0;
    logic [DW-1:0] drv_data  = '0;
    logic          drv_last  = 1'b0;

    logic          m_start, m_valid, s_start, s_valid;
    logic          m_ready, m_we, m_cpu_rst, m_done, m_error;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [AW:0]   m_loaded;
    logic          s_ready, s_we, s_cpu_rst, s_done, s_error;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [AW:0]   s_loaded;
    logic          cur_ready;

    assign m_start   = drv_start & ~sel_small;
    assign m_valid   = drv_valid & ~sel_small;
    assign s_start   = drv_start &  sel_small;
    assign s_valid   = drv_valid &  sel_small;
    assign cur_ready = sel_small ? s_ready : m_ready;

    always #5 clk = ~clk;

    instr_loader u_dut (
        .clk(clk), .rst(rst), .start(m_start), .in_valid(m_valid), .in_ready(m_ready),
        .in_data(drv_data), .in_last(drv_last), .imem_we(m_we), .imem_addr(m_addr),
        .imem_wdata(m_wdata), .cpu_rst(m_cpu_rst), .loaded_words(m_loaded),
        .done(m_done), .error(m_error)
    );

    instr_loader #(.DEPTH(4), .RELEASE_DELAY(4)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_data(drv_data), .in_last(drv_last), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .cpu_rst(s_cpu_rst), .loaded_words(s_loaded),
        .done(s_done), .error(s_error)
    );

    // Write capture for both instances.
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_data[$];
    logic [AW-1:0] sw_addr[$];

    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            wr_addr.push_back(m_addr);
            wr_data.push_back(m_wdata);
        end
        if (s_we === 1'b1) sw_addr.push_back(s_addr);
    end

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
    endtask

    // Present one word and hold it until the selected loader accepts it.
    task automatic send(input logic [DW-1:0] d, input logic last);
        int n;
        drv_valid = 1'b1;
        drv_data  = d;
        drv_last  = last;
        n = 0;
        while (cur_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        tick();
        drv_valid = 1'b0;
        drv_last  = 1'b0;
    endtask

    task automatic clear_caps();
        wr_addr.delete();
        wr_data.delete();
        sw_addr.delete();
    endtask

    initial begin
        int gaps[5];
        gaps = '{2, 0, 1, 3, 0};

        // ---------------- reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cpu_rst",  32'(m_cpu_rst), 32'd1);
        chk("rst_in_ready", 32'(m_ready),   32'd0);
        chk("rst_we",       32'(m_we),      32'd0);
        chk("rst_addr",     32'(m_addr),    32'd0);
        chk("rst_wdata",    32'(m_wdata),   32'd0);
        chk("rst_loaded",   32'(m_loaded),  32'd0);
        chk("rst_done",     32'(m_done),    32'd0);
        chk("rst_error",    32'(m_error),   32'd0);

        // ---------------- 1: good 3-word load
        clear_caps();
        pulse_start();
        chk("t1_ready_after_start", 32'(m_ready), 32'd1);
        send(10'h101, 1'b0);
        chk("t1_we_pulse", 32'(m_we), 32'd1);
        send(10'h0FF, 1'b0);
        send(10'h3FF, 1'b0);
        send(10'h1FF, 1'b1);
        chk("t1_ready_drop", 32'(m_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_settle_cpu_rst", 32'(m_cpu_rst), 32'd1);
            tick();
        end
        chk("t1_settle_cpu_rst_last", 32'(m_cpu_rst), 32'd1);
        tick();
        chk("t1_cpu_rst_released", 32'(m_cpu_rst), 32'd0);
        chk("t1_done",   32'(m_done),   32'd1);
        chk("t1_loaded", 32'(m_loaded), 32'd3);
        chk("t1_nwrites", 32'(wr_addr.size()), 32'd3);
        if (wr_addr.size() == 3) begin
            chk("t1_a0", 32'(wr_addr[0]), 32'd0); chk("t1_d0", 32'(wr_data[0]), 32'h101);
            chk("t1_a1", 32'(wr_addr[1]), 32'd1); chk("t1_d1", 32'(wr_data[1]), 32'h0FF);
            chk("t1_a2", 32'(wr_addr[2]), 32'd2); chk("t1_d2", 32'(wr_data[2]), 32'h3FF);
        end

        // ---------------- 2: bad checksum
        clear_caps();
        pulse_start();
        chk("t2_cpu_rst_on_start", 32'(m_cpu_rst), 32'd1);
        chk("t2_done_cleared",     32'(m_done),    32'd0);
        chk("t2_loaded_cleared",   32'(m_loaded),  32'd0);
        send(10'h101, 1'b0);
        send(10'h0FF, 1'b0);
        send(10'h3FF, 1'b0);
        send(10'h1FE, 1'b1);
        tick();
        tick();
        chk("t2_error",   32'(m_error),   32'd1);
        chk("t2_cpu_rst", 32'(m_cpu_rst), 32'd1);
        chk("t2_done",    32'(m_done),    32'd0);
        chk("t2_loaded",  32'(m_loaded),  32'd3);
        chk("t2_ready",   32'(m_ready),   32'd0);

        // ---------------- 3: zero-length programs
        pulse_start();
        chk("t3_error_cleared", 32'(m_error), 32'd0);
        send(10'h000, 1'b1);
        repeat (4) tick();
        chk("t3_done",    32'(m_done),    32'd1);
        chk("t3_cpu_rst", 32'(m_cpu_rst), 32'd0);
        chk("t3_loaded",  32'(m_loaded),  32'd0);
        pulse_start();
        send(10'h001, 1'b1);
        tick();
        chk("t3b_error",  32'(m_error),  32'd1);
        chk("t3b_done",   32'(m_done),   32'd0);
        chk("t3b_loaded", 32'(m_loaded), 32'd0);

        // ---------------- 4: gapped valid across 5 words
        clear_caps();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            repeat (gaps[i]) tick();
            send(10'(i + 1), 1'b0);
        end
        tick();
        send(10'h00F, 1'b1);
        repeat (6) tick();
        chk("t4_nwrites", 32'(wr_addr.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_addr.size()) begin
                chk("t4_addr", 32'(wr_addr[i]), 32'(i));
                chk("t4_data", 32'(wr_data[i]), 32'(i + 1));
            end
        end
        chk("t4_done",   32'(m_done),   32'd1);
        chk("t4_loaded", 32'(m_loaded), 32'd5);

        // ---------------- 5: overflow on the DEPTH=4 instance
        clear_caps();
        sel_small = 1'b1;
        pulse_start();
        for (int i = 0; i < 5; i++) send(10'(i + 1), 1'b0);
        tick();
        chk("t5_nwrites", 32'(sw_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < sw_addr.size()) chk("t5_addr", 32'(sw_addr[i]), 32'(i));
        chk("t5_error",   32'(s_error),   32'd1);
        chk("t5_ready",   32'(s_ready),   32'd0);
        chk("t5_loaded",  32'(s_loaded),  32'd4);
        chk("t5_cpu_rst", 32'(s_cpu_rst), 32'd1);
        sel_small = 1'b0;

        // ---------------- 6: reset mid-load, reload, restart from RUN
        clear_caps();
        pulse_start();
        send(10'h011, 1'b0);
        send(10'h022, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_cpu_rst", 32'(m_cpu_rst), 32'd1);
        chk("t6_rst_ready",   32'(m_ready),   32'd0);
        chk("t6_rst_loaded",  32'(m_loaded),  32'd0);
        tick();
        chk("t6_idle_ready",  32'(m_ready),   32'd0);
        clear_caps();
        pulse_start();
        send(10'h007, 1'b0);
        send(10'h007, 1'b1);
        repeat (4) tick();
        chk("t6_done",    32'(m_done),    32'd1);
        chk("t6_cpu_rst", 32'(m_cpu_rst), 32'd0);
        chk("t6_loaded",  32'(m_loaded),  32'd1);
        chk("t6_nwrites", 32'(wr_addr.size()), 32'd1);
        clear_caps();
        pulse_start();
        chk("t6_restart_cpu_rst", 32'(m_cpu_rst), 32'd1);
        chk("t6_restart_done",    32'(m_done),    32'd0);
        chk("t6_restart_ready",   32'(m_ready),   32'd1);
        send(10'h2AA, 1'b0);
        tick();
        chk("t6_restart_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() == 1) begin
            chk("t6_restart_addr", 32'(wr_addr[0]), 32'd0);
            chk("t6_restart_data", 32'(wr_data[0]), 32'h2AA);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Writer-side counterpart to the CPU's instruction fetch path. It accepts a stream of 10-bit instruction words over a valid/ready handshake and writes them into instruction memory starting at address 0. It verifies a trailing mod-1024 checksum word, then releases the CPU from reset. It sits between the host/debug link and the instruction memory write port, and it drives the core's reset.

Parameters:
ADDR_W, 10, instruction memory address width
DATA_W, 10, instruction word width
DEPTH, 1024, number of writable words; overflow boundary
RELEASE_DELAY, 4, cycles cpu_rst is held high after a good checksum, before release

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset; one clock only
start  in  1  single-cycle pulse; begins a load
in_valid  in  1  stream word valid
in_ready  out  1  loader accepts a word this cycle
in_data  in  DATA_W  instruction word, or checksum when in_last=1
in_last  in  1  marks the checksum word; it is not written to memory
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  write address
imem_wdata  out  DATA_W  write data
cpu_rst  out  1  reset to the CPU core; high whenever the loader is not in RUN
loaded_words  out  ADDR_W+1  count of words written in the current or last load
done  out  1  high in RUN
error  out  1  high in ERROR

Behaviour:
- Reset is synchronous and active-high on clk. Reset values:
  - state=IDLE, cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - loaded_words=0, done=0, error=0, internal checksum=0, delay counter=0.
- All outputs are registered.
- States: IDLE, LOAD, SETTLE, RUN, ERROR.
- IDLE:
  - cpu_rst=1, in_ready=0.
  - start -> LOAD; count and checksum are cleared.
- LOAD:
  - in_ready=1. A transfer occurs on in_valid & in_ready.
  - Non-last transfer with count<DEPTH:
    - The next cycle has imem_we=1, imem_addr=count, imem_wdata=in_data (1-cycle write latency).
    - count+1; checksum = (checksum + in_data) mod 2^DATA_W.
  - Non-last transfer with count==DEPTH -> ERROR (overflow); no write occurs.
  - Last transfer:
    - in_data==checksum -> SETTLE; otherwise -> ERROR.
    - in_ready drops the cycle after the last word is accepted.
  - A zero-length program (first word has in_last) is legal; it passes only if in_data==0.
  - start is ignored in LOAD.
  - in_valid low holds state; there is no timeout.
- SETTLE:
  - in_ready=0, cpu_rst=1.
  - Counts RELEASE_DELAY cycles, then -> RUN.
  - This ensures the final memory write has landed before the first fetch.
- RUN:
  - cpu_rst=0, done=1, in_ready=0.
  - start -> LOAD; cpu_rst and done change in the cycle after start is sampled.
- ERROR:
  - cpu_rst=1, error=1, in_ready=0.
  - start -> LOAD and clears error.
- loaded_words:
  - Updates on every write.
  - Holds its value through SETTLE, RUN and ERROR.
  - Clears on entry to LOAD.
- imem_we is a single-cycle pulse per accepted word. Back-to-back transfers give back-to-back writes.
- Reset mid-LOAD returns to IDLE with cpu_rst=1. Memory already written is not cleared.
- An in_valid present while in_ready=0 is not consumed. The source must hold it.

Decomposition:
- Shared package cpu10_pkg holds:
  - DATA_W=10 and ADDR_W=10, shared with the CPU, ROM and RAM.
  - The loader state enum.
  - The checksum width constant.
- The block is a single module. No sub-module is needed; the checksum is an inline accumulator.

Test Plan:
1. After rst, pulse start, then send 0x101, 0x0FF, 0x3FF, then last=0x1FF. Required response:
   - Writes occur at addr 0,1,2 with that data.
   - loaded_words=3.
   - cpu_rst stays high for 4 cycles after the last word, then drops; done=1.
2. Same three words with last=0x1FE -> error=1, cpu_rst stays 1, done=0, loaded_words=3.
3. Zero-length program:
   - Last=0x000 -> RUN with loaded_words=0.
   - Repeat with last=0x001 -> ERROR.
4. Toggle in_valid randomly across 5 words (0x001..0x005, last=0x00F). Required response:
   - Exactly 5 imem_we pulses, at addr 0..4.
   - No duplicate or dropped writes.
5. With DEPTH=4, send 5 non-last words -> 4 writes, then ERROR on the 5th; in_ready goes low.
6. Reset and re-entry:
   - Assert rst after 2 words -> IDLE, cpu_rst=1, in_ready=0.
   - Then start plus a good 1-word load -> RUN.
   - start in RUN -> cpu_rst=1 the following cycle and LOAD restarts at addr 0.
